// File: rtl/openddr_pkg.sv
// openddr_pkg: shared widths, address-mapping offsets, encoder state and
// completed-command record for the OpenDDR response-path blocks.
package openddr_pkg;

  localparam int ODDR_ADDR_WIDTH = 40;
  localparam int ODDR_BANK_WIDTH = 3;
  localparam int ODDR_ROW_WIDTH  = 16;
  localparam int ODDR_COL_WIDTH  = 10;
  localparam int ODDR_LEN_WIDTH  = 4;
  localparam int ODDR_ID_WIDTH   = 8;

  // Columns are 8-byte units, so the column field starts at byte-address bit 3.
  localparam int ODDR_COL_OFFSET = 3;

  // Bank field sits directly above the column field.
  function automatic int oddr_bank_offset(input int col_width);
    return ODDR_COL_OFFSET + col_width;
  endfunction

  // Row field sits directly above the bank field.
  function automatic int oddr_row_offset(input int col_width, input int bank_width);
    return oddr_bank_offset(col_width) + bank_width;
  endfunction

  typedef enum logic {ENC_IDLE, ENC_BURST} enc_state_t;

  typedef struct packed {
    logic [ODDR_BANK_WIDTH-1:0] bank;
    logic [ODDR_ROW_WIDTH-1:0]  row;
    logic [ODDR_COL_WIDTH-1:0]  col;
    logic [ODDR_LEN_WIDTH-1:0]  len;
    logic [ODDR_ID_WIDTH-1:0]   id;
  } ddr_cmd_cpl_t;

endpackage

// File: rtl/openddr_addr_encoder_if.sv
// openddr_addr_encoder_if: command-in and beat-out channels of the burst
// address encoder.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. Once valid is raised the payload must
// hold steady until that transfer; ready may change freely. The encoder's
// in_ready never depends on in_valid.
interface openddr_addr_encoder_if
  import openddr_pkg::*;
#(
  parameter int ADDR_WIDTH = ODDR_ADDR_WIDTH,
  parameter int BANK_WIDTH = ODDR_BANK_WIDTH,
  parameter int ROW_WIDTH  = ODDR_ROW_WIDTH,
  parameter int COL_WIDTH  = ODDR_COL_WIDTH,
  parameter int LEN_WIDTH  = ODDR_LEN_WIDTH,
  parameter int ID_WIDTH   = ODDR_ID_WIDTH
);

  logic                  in_valid;
  logic                  in_ready;
  logic [BANK_WIDTH-1:0] in_bank;
  logic [ROW_WIDTH-1:0]  in_row;
  logic [COL_WIDTH-1:0]  in_col;
  logic [LEN_WIDTH-1:0]  in_len;
  logic [ID_WIDTH-1:0]   in_id;

  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [ID_WIDTH-1:0]   out_id;
  logic                  out_last;
  logic                  out_err;

  // Scheduler side: issues commands, consumes beats.
  modport master (
    output in_valid, in_bank, in_row, in_col, in_len, in_id, out_ready,
    input  in_ready, out_valid, out_addr, out_id, out_last, out_err
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_bank, in_row, in_col, in_len, in_id, out_ready,
    output in_ready, out_valid, out_addr, out_id, out_last, out_err
  );

endinterface

// File: rtl/openddr_addr_pack.sv
// openddr_addr_pack: combinational {row, bank, col} to AXI byte address
// packer. Bits above the row field are zero.
module openddr_addr_pack
  import openddr_pkg::*;
#(
  parameter int ADDR_WIDTH = ODDR_ADDR_WIDTH,
  parameter int BANK_WIDTH = ODDR_BANK_WIDTH,
  parameter int ROW_WIDTH  = ODDR_ROW_WIDTH,
  parameter int COL_WIDTH  = ODDR_COL_WIDTH
) (
  input  logic [ROW_WIDTH-1:0]  i_row,
  input  logic [BANK_WIDTH-1:0] i_bank,
  input  logic [COL_WIDTH-1:0]  i_col,
  output logic [ADDR_WIDTH-1:0] o_addr
);

  localparam int BANK_OFFSET = oddr_bank_offset(COL_WIDTH);
  localparam int ROW_OFFSET  = oddr_row_offset(COL_WIDTH, BANK_WIDTH);

  // The mapped fields must fit inside the AXI address.
  if (ROW_OFFSET + ROW_WIDTH > ADDR_WIDTH) begin : g_map_too_wide
    $error("openddr_addr_pack: row field exceeds ADDR_WIDTH");
  end

  // Place each field at its fixed offset; everything else is zero.
  always_comb begin
    o_addr = '0;
    o_addr[ODDR_COL_OFFSET +: COL_WIDTH] = i_col;
    o_addr[BANK_OFFSET +: BANK_WIDTH]    = i_bank;
    o_addr[ROW_OFFSET +: ROW_WIDTH]      = i_row;
  end

endmodule

// File: rtl/openddr_addr_encoder.sv
// openddr_addr_encoder: rebuilds the AXI byte address of every data beat of
// a completed DDR column command, one beat per output handshake.
// Optional feature macro: OPENDDR_ADDR_ENC_WRAP_EN selects wrap-burst column
// ordering for power-of-two burst lengths.
module openddr_addr_encoder
  import openddr_pkg::*;
#(
  parameter int ADDR_WIDTH = ODDR_ADDR_WIDTH,
  parameter int BANK_WIDTH = ODDR_BANK_WIDTH,
  parameter int ROW_WIDTH  = ODDR_ROW_WIDTH,
  parameter int COL_WIDTH  = ODDR_COL_WIDTH,
  parameter int LEN_WIDTH  = ODDR_LEN_WIDTH,
  parameter int ID_WIDTH   = ODDR_ID_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  openddr_addr_encoder_if.slave bus,
  output enc_state_t o_dbg_state
);

  enc_state_t r_state;
  enc_state_t w_state_nxt;

  // Latched command; r_col is the burst's starting column.
  logic [BANK_WIDTH-1:0] r_bank;
  logic [ROW_WIDTH-1:0]  r_row;
  logic [COL_WIDTH-1:0]  r_col;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [ID_WIDTH-1:0]   r_id;
  logic [LEN_WIDTH-1:0]  r_beat;

  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic [ID_WIDTH-1:0]   r_out_id;
  logic                  r_out_last;
  logic                  r_out_err;

  logic w_out_valid;
  logic w_in_ready;
  logic w_load;
  logic w_adv;
  logic w_end;

  // Parameters of the beat that will be presented after the next edge.
  logic [BANK_WIDTH-1:0] w_src_bank;
  logic [ROW_WIDTH-1:0]  w_src_row;
  logic [COL_WIDTH-1:0]  w_src_col;
  logic [LEN_WIDTH-1:0]  w_src_len;
  logic [ID_WIDTH-1:0]   w_src_id;
  logic [LEN_WIDTH-1:0]  w_k;
  logic [COL_WIDTH:0]    w_lin;
  logic [COL_WIDTH-1:0]  w_col;
  logic                  w_err;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_out_valid = (r_state == ENC_BURST);
  assign w_end       = w_out_valid & bus.out_ready & r_out_last;
  assign w_adv       = w_out_valid & bus.out_ready & ~r_out_last;
  // Accept a new command when idle or while the last beat leaves, so
  // back-to-back bursts have no bubble.
  assign w_in_ready  = ~rst & ((r_state == ENC_IDLE) | w_end);
  assign w_load      = bus.in_valid & w_in_ready;

  // Next-state logic: IDLE -> BURST on a command; BURST ends on last beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ENC_IDLE:  if (bus.in_valid) w_state_nxt = ENC_BURST;
      ENC_BURST: if (w_end) w_state_nxt = bus.in_valid ? ENC_BURST : ENC_IDLE;
      default:   w_state_nxt = ENC_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ENC_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Select the command and beat index for the next presented beat.
  always_comb begin
    w_src_bank = r_bank;
    w_src_row  = r_row;
    w_src_col  = r_col;
    w_src_len  = r_len;
    w_src_id   = r_id;
    w_k        = r_beat + 1'b1;
    if (w_load) begin
      w_src_bank = bus.in_bank;
      w_src_row  = bus.in_row;
      w_src_col  = bus.in_col;
      w_src_len  = bus.in_len;
      w_src_id   = bus.in_id;
      w_k        = '0;
    end
  end

`ifdef OPENDDR_ADDR_ENC_WRAP_EN
  logic [LEN_WIDTH:0]   w_beats;
  logic                 w_pow2;
  logic [COL_WIDTH-1:0] w_mask;

  // Wrap ordering keeps power-of-two bursts inside their aligned block;
  // other lengths fall back to linear order and are flagged.
  always_comb begin
    w_lin   = (COL_WIDTH+1)'(w_src_col) + (COL_WIDTH+1)'(w_k);
    w_beats = (LEN_WIDTH+1)'(w_src_len) + (LEN_WIDTH+1)'(1);
    w_pow2  = ((w_beats & (w_beats - 1'b1)) == '0);
    w_mask  = COL_WIDTH'(w_src_len);
    w_col   = w_lin[COL_WIDTH-1:0];
    w_err   = 1'b1;
    if (w_pow2) begin
      w_col = (w_src_col & ~w_mask) | (w_lin[COL_WIDTH-1:0] & w_mask);
      w_err = 1'b0;
    end
    w_last = (w_k == w_src_len);
  end
`else
  // Linear ordering: the column wraps inside the row and the carry out of
  // the column field flags the beat as a row overflow.
  always_comb begin
    w_lin  = (COL_WIDTH+1)'(w_src_col) + (COL_WIDTH+1)'(w_k);
    w_col  = w_lin[COL_WIDTH-1:0];
    w_err  = w_lin[COL_WIDTH];
    w_last = (w_k == w_src_len);
  end
`endif

  openddr_addr_pack #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BANK_WIDTH (BANK_WIDTH),
    .ROW_WIDTH  (ROW_WIDTH),
    .COL_WIDTH  (COL_WIDTH)
  ) u_pack (
    .i_row  (w_src_row),
    .i_bank (w_src_bank),
    .i_col  (w_col),
    .o_addr (w_addr)
  );

  // Register the next beat on a load or an advancing handshake; a stall
  // leaves everything untouched so the presented beat holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_len      <= '0;
      r_id       <= '0;
      r_beat     <= '0;
      r_out_addr <= '0;
      r_out_id   <= '0;
      r_out_last <= 1'b0;
      r_out_err  <= 1'b0;
    end else if (w_load || w_adv) begin
      if (w_load) begin
        r_bank <= bus.in_bank;
        r_row  <= bus.in_row;
        r_col  <= bus.in_col;
        r_len  <= bus.in_len;
        r_id   <= bus.in_id;
      end
      r_beat     <= w_k;
      r_out_addr <= w_addr;
      r_out_id   <= w_src_id;
      r_out_last <= w_last;
      r_out_err  <= w_err;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_id    = r_out_id;
  assign bus.out_last  = r_out_last;
  assign bus.out_err   = r_out_err;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_openddr_addr_encoder.sv
// tb_openddr_addr_encoder: directed bench for the burst address encoder.
// Expected beats are hand-computed and queued in exp_q; each presented beat
// is compared against the queue head.
module tb_openddr_addr_encoder;
  import openddr_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  enc_state_t dbg_state;

  always #5 clk = ~clk;

  openddr_addr_encoder_if bus ();

  openddr_addr_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  // {addr[39:0], id[7:0], last, err}
  logic [49:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [49:0] mk(input logic [39:0] a, input logic [7:0] id,
                                     input logic last, input logic err);
    return {a, id, last, err};
  endfunction

  function automatic ddr_cmd_cpl_t mkcmd(input logic [2:0] bank, input logic [15:0] row,
                                         input logic [9:0] col, input logic [3:0] len,
                                         input logic [7:0] id);
    ddr_cmd_cpl_t c;
    c.bank = bank; c.row = row; c.col = col; c.len = len; c.id = id;
    return c;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input ddr_cmd_cpl_t c);
    bus.in_valid = 1'b1;
    bus.in_bank  = c.bank;
    bus.in_row   = c.row;
    bus.in_col   = c.col;
    bus.in_len   = c.len;
    bus.in_id    = c.id;
  endtask

  task automatic send_cmd(input ddr_cmd_cpl_t c);
    drive_cmd(c);
    chk("cmd_in_ready", 64'(bus.in_ready), 64'd1);
    step;
    bus.in_valid = 1'b0;
  endtask

  // Compare the presented beat against the queue head (no pop).
  task automatic chk_beat(input string tag);
    logic [49:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q[0];
      chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, "_addr"},  64'(bus.out_addr),  64'(e[49:10]));
      chk({tag, "_id"},    64'(bus.out_id),    64'(e[9:2]));
      chk({tag, "_last"},  64'(bus.out_last),  64'(e[1]));
      chk({tag, "_err"},   64'(bus.out_err),   64'(e[0]));
    end
  endtask

  task automatic pop_exp;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  // Consume n beats; optionally stall before beat stall_beat.
  task automatic run_burst(input string tag, input int n, input int stall_beat,
                           input int stall_len);
    int waited;
    for (int b = 0; b < n; b++) begin
      waited = 0;
      while (!bus.out_valid && waited < 20) begin
        step;
        waited++;
      end
      chk({tag, "_no_bubble"}, 64'(waited), 64'd0);
      if (!bus.out_valid) return;
      if (b == stall_beat) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          chk_beat({tag, "_stall"});
          chk({tag, "_stall_in_ready"}, 64'(bus.in_ready), 64'd0);
          step;
        end
      end
      bus.out_ready = 1'b1;
      chk_beat(tag);
      chk({tag, "_in_ready"}, 64'(bus.in_ready), (b == n - 1) ? 64'd1 : 64'd0);
      pop_exp();
      step;
    end
    chk({tag, "_done_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_done_state"}, 64'(dbg_state), 64'(ENC_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_bank   = '0;
    bus.in_row    = '0;
    bus.in_col    = '0;
    bus.in_len    = '0;
    bus.in_id     = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;

    // Reset state
    step;
    chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_addr",  64'(bus.out_addr),  64'd0);
    chk("rst_out_id",    64'(bus.out_id),    64'd0);
    chk("rst_out_last",  64'(bus.out_last),  64'd0);
    chk("rst_out_err",   64'(bus.out_err),   64'd0);
    chk("rst_state",     64'(dbg_state),     64'(ENC_IDLE));
    step;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Linear burst
    exp_q.push_back(mk(40'h00_1234_BF80, 8'hA5, 1'b0, 1'b0));
    exp_q.push_back(mk(40'h00_1234_BF88, 8'hA5, 1'b0, 1'b0));
    exp_q.push_back(mk(40'h00_1234_BF90, 8'hA5, 1'b0, 1'b0));
    exp_q.push_back(mk(40'h00_1234_BF98, 8'hA5, 1'b1, 1'b0));
    send_cmd(mkcmd(3'd5, 16'h1234, 10'h3F0, 4'd3, 8'hA5));
    run_burst("linear", 4, -1, 0);

`ifdef OPENDDR_ADDR_ENC_WRAP_EN
    // Wrap, power-of-two length: stays inside block 0x3FC..0x3FF
    exp_q.push_back(mk(40'h1FF0, 8'h01, 1'b0, 1'b0));
    exp_q.push_back(mk(40'h1FF8, 8'h01, 1'b0, 1'b0));
    exp_q.push_back(mk(40'h1FE0, 8'h01, 1'b0, 1'b0));
    exp_q.push_back(mk(40'h1FE8, 8'h01, 1'b1, 1'b0));
    send_cmd(mkcmd(3'd0, 16'h0000, 10'h3FE, 4'd3, 8'h01));
    run_burst("wrap_pow2", 4, -1, 0);
    // Wrap, non-power-of-two length: linear order, flagged
    exp_q.push_back(mk(40'h1FF0, 8'h02, 1'b0, 1'b1));
    exp_q.push_back(mk(40'h1FF8, 8'h02, 1'b0, 1'b1));
    exp_q.push_back(mk(40'h0000, 8'h02, 1'b1, 1'b1));
    send_cmd(mkcmd(3'd0, 16'h0000, 10'h3FE, 4'd2, 8'h02));
    run_burst("wrap_npow2", 3, -1, 0);
`else
    // Row overflow: column wraps inside the row and is flagged
    exp_q.push_back(mk(40'h1FF0, 8'h01, 1'b0, 1'b0));
    exp_q.push_back(mk(40'h1FF8, 8'h01, 1'b0, 1'b0));
    exp_q.push_back(mk(40'h0000, 8'h01, 1'b0, 1'b1));
    exp_q.push_back(mk(40'h0008, 8'h01, 1'b1, 1'b1));
    send_cmd(mkcmd(3'd0, 16'h0000, 10'h3FE, 4'd3, 8'h01));
    run_burst("row_ovf", 4, -1, 0);
`endif

    // Backpressure: 3 stall cycles at beat 1
    bus.out_ready = 1'b0;
    exp_q.push_back(mk(40'h00_00AB_4080, 8'h33, 1'b0, 1'b0));
    exp_q.push_back(mk(40'h00_00AB_4088, 8'h33, 1'b0, 1'b0));
    exp_q.push_back(mk(40'h00_00AB_4090, 8'h33, 1'b0, 1'b0));
    exp_q.push_back(mk(40'h00_00AB_4098, 8'h33, 1'b1, 1'b0));
    send_cmd(mkcmd(3'd2, 16'h00AB, 10'h010, 4'd3, 8'h33));
    run_burst("stall", 4, 1, 3);

    // Back-to-back: command B offered during A's last-beat handshake
    exp_q.push_back(mk(40'h1_2000, 8'h11, 1'b0, 1'b0));
    exp_q.push_back(mk(40'h1_2008, 8'h11, 1'b1, 1'b0));
    exp_q.push_back(mk(40'h2_6100, 8'h22, 1'b1, 1'b0));
    send_cmd(mkcmd(3'd1, 16'h0001, 10'h000, 4'd1, 8'h11));
    bus.out_ready = 1'b1;
    chk_beat("b2b_a0");
    pop_exp();
    step;
    chk_beat("b2b_a1");
    pop_exp();
    drive_cmd(mkcmd(3'd3, 16'h0002, 10'h020, 4'd0, 8'h22));
    chk("b2b_in_ready", 64'(bus.in_ready), 64'd1);
    step;
    bus.in_valid = 1'b0;
    chk_beat("b2b_b0");
    pop_exp();
    step;
    chk("b2b_done_valid", 64'(bus.out_valid), 64'd0);

    // Reset mid-burst at beat 1 of a len=7 burst
    exp_q.push_back(mk(40'h55_2000, 8'h77, 1'b0, 1'b0));
    send_cmd(mkcmd(3'd1, 16'h0055, 10'h000, 4'd7, 8'h77));
    chk_beat("mid_b0");
    pop_exp();
    step;
    chk("mid_b1_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    step;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_addr",  64'(bus.out_addr),  64'd0);
    chk("mid_rst_id",    64'(bus.out_id),    64'd0);
    chk("mid_rst_last",  64'(bus.out_last),  64'd0);
    chk("mid_rst_err",   64'(bus.out_err),   64'd0);
    chk("mid_rst_state", 64'(dbg_state),     64'(ENC_IDLE));
    rst = 1'b0;
    #1;
    chk("mid_release_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("mid_no_stale_beat", 64'(bus.out_valid), 64'd0);
    end
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/openddr_addr_encoder.md
# openddr_addr_encoder

Burst address generator for the OpenDDR read/write response path. It accepts completed DDR column commands (bank, row, column, burst length, transaction ID) and rebuilds the AXI byte address of every data beat, using the controller's fixed address mapping. One output beat is emitted per handshake. It sits between the command scheduler's completion queue and the AXI R/B response formatter.

## Interface
- ADDR_WIDTH, 40, AXI byte address width
- BANK_WIDTH, 3, bank address width
- ROW_WIDTH, 16, row address width
- COL_WIDTH, 10, column address width (8-byte units)
- LEN_WIDTH, 4, burst length field width (beats minus one)
- ID_WIDTH, 8, transaction ID width

Ports:
- clk  in  1  single clock; all logic rises on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  command completion valid
- in_ready  out  1  encoder can accept a command
- in_bank  in  BANK_WIDTH  bank of the command
- in_row  in  ROW_WIDTH  row of the command
- in_col  in  COL_WIDTH  starting column
- in_len  in  LEN_WIDTH  beats minus one
- in_id  in  ID_WIDTH  transaction ID
- out_valid  out  1  beat address valid
- out_ready  in  1  downstream accepts the beat
- out_addr  out  ADDR_WIDTH  reconstructed AXI byte address
- out_id  out  ID_WIDTH  ID of the current burst
- out_last  out  1  final beat of the burst
- out_err  out  1  beat column is invalid (see Operation)

## Operation
- Mapping: out_addr = {zeros, row, bank, col, 3'b000}. COL_OFFSET=3, BANK_OFFSET=3+COL_WIDTH, ROW_OFFSET=BANK_OFFSET+BANK_WIDTH. Bits at ROW_OFFSET+ROW_WIDTH and above are zero. ROW_OFFSET+ROW_WIDTH must be <= ADDR_WIDTH; an elaboration-time assertion enforces this.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid, latch the command, set beat=0, go to BURST.
  - BURST: out_valid=1. On an out handshake with beat<len, beat increments. On an out handshake with beat==len (out_last=1), the burst ends:
    - if in_valid is also high, the new command is latched and the FSM stays in BURST (no bubble);
    - otherwise the FSM goes to IDLE.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). in_ready is 0 while rst is high.
- Column of beat k (linear): (start_col + k) mod 2^COL_WIDTH. The column never carries into the bank or row fields.
- out_err is set on every beat whose linear column has wrapped past 2^COL_WIDTH-1 (row overflow).
- out_last = (beat==len).
- Stall: while out_valid=1 and out_ready=0, out_addr, out_id, out_last and out_err hold constant.

## Timing
- Reset values:
  - state IDLE, beat 0
  - out_valid 0, out_addr 0, out_id 0, out_last 0, out_err 0
  - in_ready 0 while in reset, 1 in the first cycle after reset
- Latency: a command accepted in cycle N presents beat 0 in cycle N+1.
- Throughput: 1 beat/cycle with out_ready held high, including across back-to-back bursts.
- out_* are registered. in_ready is combinational from state, out_ready and out_last only; there is no path from in_valid.
- Reset mid-burst: the burst is discarded. out_valid drops in the cycle after rst is sampled, and no remaining beats are emitted.
- len=0: one beat, out_last=1.

## Configuration
- OPENDDR_ADDR_ENC_WRAP_EN defined: wrap-burst ordering.
  - With L=len+1 a power of two, the column of beat k is (start & ~(L-1)) | ((start+k) & (L-1)). The burst stays inside its aligned block and out_err=0.
  - With L not a power of two, linear ordering is used and out_err=1 on every beat.
- OPENDDR_ADDR_ENC_WRAP_EN undefined: linear ordering only, with the row-overflow out_err rule.

## Structure
- openddr_pkg gains:
  - localparams ODDR_COL_OFFSET and the mapping offset functions;
  - typedef enum logic {ENC_IDLE, ENC_BURST} enc_state_t;
  - typedef struct ddr_cmd_cpl_t {bank, row, col, len, id}.
- One sub-module, openddr_addr_pack: a combinational {row,bank,col} to ADDR_WIDTH packer. The encoder instantiates it on the next-column value so that out_addr can be registered.

## Test plan
- Linear burst: row=0x1234, bank=5, col=0x3F0, len=3, out_ready=1 -> out_addr 0x1234BF80, BF88, BF90, BF98 on consecutive cycles starting one cycle after acceptance; out_last on the 4th beat; out_err=0; out_id echoed.
- Row overflow, macro off: row=0, bank=0, col=0x3FE, len=3 -> addresses 0x1FF0, 0x1FF8, 0x0000, 0x0008; out_err=0, 0, 1, 1.
- Wrap, macro on: col=0x3FC block, start 0x3FE, len=3 -> columns 0x3FE, 0x3FF, 0x3FC, 0x3FD; out_err=0 on all beats. Same command with len=2 -> out_err=1 on all 3 beats.
- Backpressure: out_ready low for 3 cycles at beat 1 -> out_addr, out_last, out_err and out_id stable throughout; in_ready=0; beats resume in order with no loss.
- Back-to-back: second command valid during the last-beat handshake of the first -> in_ready=1 in that cycle; beat 0 of the second command in the next cycle; no idle cycle.
- Reset mid-burst: rst high at beat 1 of a len=7 burst -> out_valid=0 the following cycle, all outputs 0, no stale beats after rst is released; in_ready=1 in the first cycle after release.
